// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flags, evaluates the condition field and
// gates PC/register/memory writes with the condition result registered one cycle earlier.
module cond_unit #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q, cond_ex_delayed_d;
  logic [1:0] flag_write;
  logic       n, z, c, v;
  logic       cond_ex;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = ~(n ^ v);
      4'b1011: cond_ex = n ^ v;
      4'b1100: cond_ex = ~z & ~(n ^ v);
      4'b1101: cond_ex = z | (n ^ v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Logical AND keeps an unknown condition from enabling a write when FlagW is 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_flag_write
    assign flag_write[gi] = FlagW[gi] && cond_ex;
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
    if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
    cond_ex_delayed_d = cond_ex;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q           <= FLAGS_RESET;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  // Gated writes use the condition evaluated one cycle earlier, against pre-update flags.
  assign PCWrite  = (PCS & cond_ex_delayed_q) | NextPC;
  assign RegWrite = RegW & cond_ex_delayed_q;
  assign MemWrite = MemW & cond_ex_delayed_q;
  assign Flags    = flags_q;
  assign CondEx   = cond_ex;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: reset, gating, flag-write timing and a full Cond x Flags sweep.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW;
  logic       PCWrite, RegWrite, MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  int checks = 0;
  int errors = 0;

  cond_unit #(.FLAGS_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-16s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One AL cycle writing all four flags; leaves FlagW cleared afterwards.
  task automatic set_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    step();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b1; MemW = 1'b1;
    step();
    step();
    settle();
    check("rst_flags", Flags, 4'b0000);
    check("rst_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("rst_memwrite", {3'b0, MemWrite}, 4'b0000);
    check("rst_pcwrite", {3'b0, PCWrite}, 4'b0000);
    NextPC = 1'b1; settle();
    check("rst_nextpc", {3'b0, PCWrite}, 4'b0001);
    reset = 1'b0; FlagW = 2'b00; RegW = 1'b0; MemW = 1'b0; NextPC = 1'b0;
    step();

    // EQ true
    set_flags(4'b0100);
    Cond = 4'b0000; settle();
    check("eq_condex", {3'b0, CondEx}, 4'b0001);
    step();
    RegW = 1'b1; settle();
    check("eq_regwrite", {3'b0, RegWrite}, 4'b0001);
    RegW = 1'b0;

    // EQ false
    set_flags(4'b0000);
    Cond = 4'b0000; settle();
    check("ne_condex", {3'b0, CondEx}, 4'b0000);
    step();
    RegW = 1'b1; settle();
    check("ne_regwrite", {3'b0, RegWrite}, 4'b0000);
    RegW = 1'b0;

    // Partial flag write: only N,Z
    set_flags(4'b0000);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    step();
    FlagW = 2'b00; settle();
    check("partial_nz", Flags, 4'b1100);

    // Suppressed flag write
    set_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100;
    step();
    FlagW = 2'b00; settle();
    check("suppressed", Flags, 4'b0000);

    // Flag-setting instruction evaluates against pre-update flags
    set_flags(4'b0100);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0000; settle();
    check("preupd_condex", {3'b0, CondEx}, 4'b0001);
    step();
    FlagW = 2'b00; RegW = 1'b1; settle();
    check("postupd_flags", Flags, 4'b0000);
    check("postupd_condex", {3'b0, CondEx}, 4'b0000);
    check("postupd_regwr", {3'b0, RegWrite}, 4'b0001);
    RegW = 1'b0;

    // Branch GE
    set_flags(4'b1001);
    Cond = 4'b1010; PCS = 1'b1;
    step();
    settle();
    check("ge_pcwrite", {3'b0, PCWrite}, 4'b0001);
    PCS = 1'b0;
    set_flags(4'b1000);
    Cond = 4'b1010; PCS = 1'b1;
    step();
    settle();
    check("lt_pcwrite", {3'b0, PCWrite}, 4'b0000);
    NextPC = 1'b1; settle();
    check("nextpc_pcwrite", {3'b0, PCWrite}, 4'b0001);
    PCS = 1'b0; NextPC = 1'b0;

    // Cond=1111 always executes
    set_flags(4'b0000);
    Cond = 4'b1111; settle();
    check("nv_condex", {3'b0, CondEx}, 4'b0001);

    // Unknown Cond with FlagW=00 leaves flags intact
    set_flags(4'b1010);
    Cond = 4'bxxxx; FlagW = 2'b00; ALUFlags = 4'b0101;
    step();
    settle();
    check("x_cond_flags", Flags, 4'b1010);
    Cond = 4'b1110;
    step();

    // Reset beats a same-cycle flag write and drops pending writes
    set_flags(4'b0110);
    reset = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
    step();
    reset = 1'b0; FlagW = 2'b00; RegW = 1'b1; MemW = 1'b1; settle();
    check("midrst_flags", Flags, 4'b0000);
    check("midrst_regwrite", {3'b0, RegWrite}, 4'b0000);
    check("midrst_memwrite", {3'b0, MemWrite}, 4'b0000);
    RegW = 1'b0; MemW = 1'b0;

    // Full sweep of Cond x Flags
    for (int ci = 0; ci < 16; ci++) begin
      for (int fi = 0; fi < 16; fi++) begin
        logic [3:0] cv, fv;
        logic       exp;
        cv = ci[3:0]; fv = fi[3:0];
        exp = ref_cond(cv, fv);
        MemW = 1'b0;
        set_flags(fv);
        Cond = cv; settle();
        checks++;
        assert (CondEx === exp) else begin
          errors++;
          $error("FAIL sweep_condex cond=%b flags=%b observed=%b expected=%b", cv, fv, CondEx, exp);
        end
        step();
        MemW = 1'b1; settle();
        checks++;
        assert (MemWrite === exp) else begin
          errors++;
          $error("FAIL sweep_memwrite cond=%b flags=%b observed=%b expected=%b", cv, fv, MemWrite, exp);
        end
      end
    end
    $display("sweep done: 256 cond/flags combinations");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
